cu_int_seq: RTL and testbench

- Parametrised interrupt capture and sequencing unit for the CPU control unit. It is the successor to the single-IRQ capture stage.
- Accepts one NMI and N_IRQ maskable IRQ channels, plus the BRK opcode indication and reset.
- Arbitrates these at instruction boundaries, holds a request/acknowledge handshake with the CU FSM, and steps through the 7-cycle interrupt sequence.
- Supplies vector address, B-flag value and sequence step to the control generator, including 6502-style NMI hijack of IRQ/BRK sequences.

---
 rtl/cu_pkg.sv | 27 ++
 rtl/cu_int_seq_if.sv | 36 +++
 rtl/cu_nmi_edge.sv | 37 +++
 rtl/cu_int_seq.sv | 141 ++++++++++++++
 tb/tb_cu_int_seq.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the CPU control-unit interrupt sequencer.
// Holds the interrupt kind and sequencer state encodings, default vectors and step limits.
package cu_pkg;

    typedef enum logic [1:0] {
        INT_BRK = 2'b00,
        INT_RST = 2'b01,
        INT_NMI = 2'b10,
        INT_IRQ = 2'b11
    } int_kind_e;

    typedef enum logic [1:0] {
        S_RST_PEND,
        S_IDLE,
        S_ARMED,
        S_SEQ
    } cu_int_state_e;

    localparam logic [15:0] DEF_VEC_NMI      = 16'hFFFA;
    localparam logic [15:0] DEF_VEC_RST      = 16'hFFFC;
    localparam logic [15:0] DEF_VEC_IRQ      = 16'hFFFE;
    localparam logic [15:0] DEF_VEC_EXT_BASE = 16'hFFF0;

    localparam logic [2:0] SEQ_LAST    = 3'd6;
    localparam logic [2:0] HIJACK_LAST = 3'd3;

endpackage

// File: rtl/cu_int_seq_if.sv
// Interrupt source / CU FSM bundle for cu_int_seq.
// master = CU side driving sources, boundary and ack; slave = the sequencer.
interface cu_int_seq_if #(
    parameter int N_IRQ = 1
) ();
    localparam int CHW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    logic             CU_bNMI;
    logic [N_IRQ-1:0] CU_bIRQ;
    logic [N_IRQ-1:0] irq_en;
    logic             flag_i;
    logic             insn_bnd;
    logic             brk_op;
    logic             int_ack;

    logic             int_req;
    logic [1:0]       int_kind;
    logic [CHW-1:0]   int_chan;
    logic [15:0]      vec_addr;
    logic             set_b;
    logic             seq_busy;
    logic [2:0]       seq_step;
    logic             nmi_pend;

    modport master (
        output CU_bNMI, CU_bIRQ, irq_en, flag_i, insn_bnd, brk_op, int_ack,
        input  int_req, int_kind, int_chan, vec_addr, set_b, seq_busy,
        input  seq_step, nmi_pend
    );

    modport slave (
        input  CU_bNMI, CU_bIRQ, irq_en, flag_i, insn_bnd, brk_op, int_ack,
        output int_req, int_kind, int_chan, vec_addr, set_b, seq_busy,
        output seq_step, nmi_pend
    );
endinterface

// File: rtl/cu_nmi_edge.sv
// NMI synchroniser (NMI_SYNC flops, reset to 1) plus falling-edge detector and pending latch.
// Ports: clk_i, rst_i, bnmi_i (active-low NMI), clr_i, fall_o (edge this cycle), pend_o.
module cu_nmi_edge #(
    parameter int NMI_SYNC = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bnmi_i,
    input  logic clr_i,
    output logic fall_o,
    output logic pend_o
);
    logic [NMI_SYNC-1:0] sync_q;
    logic                prev_q;
    logic                pend_q;
    logic                pend_d;

    assign fall_o = prev_q & ~sync_q[NMI_SYNC-1];
    // a fresh edge beats a clear in the same cycle
    assign pend_d = fall_o | (pend_q & ~clr_i);
    assign pend_o = pend_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            pend_q <= 1'b0;
        end else begin
            sync_q[0] <= bnmi_i;
            for (int i = 1; i < NMI_SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[NMI_SYNC-1];
            pend_q <= pend_d;
        end
    end
endmodule

// File: rtl/cu_int_seq.sv
// Interrupt capture, arbitration and 7-step sequencing for the CPU control unit.
// Ports: CU_phi2 clock, CU_rst async active-high reset, bus (cu_int_seq_if.slave).
module cu_int_seq import cu_pkg::*; #(
    parameter int          N_IRQ        = 1,
    parameter int          NMI_SYNC     = 2,
    parameter logic [15:0] VEC_NMI      = DEF_VEC_NMI,
    parameter logic [15:0] VEC_RST      = DEF_VEC_RST,
    parameter logic [15:0] VEC_IRQ      = DEF_VEC_IRQ,
    parameter logic [15:0] VEC_EXT_BASE = DEF_VEC_EXT_BASE
) (
    input  logic         CU_phi2,
    input  logic         CU_rst,
    cu_int_seq_if.slave  bus
);
    localparam int CHW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    cu_int_state_e  state_q;
    int_kind_e      kind_q;
    logic [CHW-1:0] chan_q;
    logic [15:0]    vec_q;
    logic           setb_q;
    logic [2:0]     step_q;

    logic             nmi_fall;
    logic             nmi_pend;
    logic             nmi_clr;
    logic             nmi_hit;
    logic             hij_ok;
    logic [N_IRQ-1:0] irq_act;
    logic             irq_any;
    logic [CHW-1:0]   irq_win;
    logic [CHW-1:0]   ch_m1;
    logic [15:0]      irq_vec;

    cu_nmi_edge #(.NMI_SYNC(NMI_SYNC)) u_nmi (
        .clk_i  (CU_phi2),
        .rst_i  (CU_rst),
        .bnmi_i (bus.CU_bNMI),
        .clr_i  (nmi_clr),
        .fall_o (nmi_fall),
        .pend_o (nmi_pend)
    );

    assign irq_act = ~bus.CU_bIRQ & bus.irq_en & {N_IRQ{~bus.flag_i}};

    // lowest active index wins
    always_comb begin
        irq_any = 1'b0;
        irq_win = '0;
        for (int c = N_IRQ - 1; c >= 0; c--) begin
            if (irq_act[c]) begin
                irq_any = 1'b1;
                irq_win = CHW'(c);
            end
        end
    end

    assign ch_m1   = irq_win - CHW'(1);
    assign irq_vec = (irq_win == '0) ? VEC_IRQ :
                     VEC_EXT_BASE + {{(15 - CHW){1'b0}}, ch_m1, 1'b0};

    assign nmi_hit = nmi_pend | nmi_fall;
    assign hij_ok  = (kind_q == INT_BRK) || (kind_q == INT_IRQ);
    assign nmi_clr = (state_q == S_SEQ) && (kind_q == INT_NMI) &&
                     (step_q == HIJACK_LAST + 3'd1);

    always_ff @(posedge CU_phi2 or posedge CU_rst) begin
        if (CU_rst) begin
            state_q <= S_RST_PEND;
            kind_q  <= INT_RST;
            chan_q  <= '0;
            vec_q   <= VEC_RST;
            setb_q  <= 1'b0;
            step_q  <= 3'd0;
        end else begin
            unique case (state_q)
                S_RST_PEND: begin
                    if (bus.int_ack) begin
                        state_q <= S_SEQ;
                        step_q  <= 3'd0;
                    end
                end
                S_IDLE: begin
                    if (bus.insn_bnd) begin
                        if (nmi_hit) begin
                            state_q <= S_ARMED;
                            kind_q  <= INT_NMI;
                            chan_q  <= '0;
                            vec_q   <= VEC_NMI;
                            setb_q  <= 1'b0;
                        end else if (irq_any) begin
                            state_q <= S_ARMED;
                            kind_q  <= INT_IRQ;
                            chan_q  <= irq_win;
                            vec_q   <= irq_vec;
                            setb_q  <= 1'b0;
                        end else if (bus.brk_op) begin
                            state_q <= S_ARMED;
                            kind_q  <= INT_BRK;
                            chan_q  <= '0;
                            vec_q   <= VEC_IRQ;
                            setb_q  <= 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (bus.int_ack) begin
                        state_q <= S_SEQ;
                        step_q  <= 3'd0;
                    end else if (nmi_hit && hij_ok) begin
                        kind_q <= INT_NMI;
                        vec_q  <= VEC_NMI;
                    end
                end
                S_SEQ: begin
                    if (step_q == SEQ_LAST) begin
                        state_q <= S_IDLE;
                        step_q  <= 3'd0;
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                    // hijack keeps set_b so a BRK still pushes B=1
                    if (hij_ok && (step_q <= HIJACK_LAST) && nmi_pend) begin
                        kind_q <= INT_NMI;
                        vec_q  <= VEC_NMI;
                    end
                end
                default: state_q <= S_RST_PEND;
            endcase
        end
    end

    assign bus.int_req  = (state_q == S_RST_PEND) || (state_q == S_ARMED);
    assign bus.seq_busy = (state_q == S_SEQ);
    assign bus.int_kind = kind_q;
    assign bus.int_chan = chan_q;
    assign bus.vec_addr = vec_q;
    assign bus.set_b    = setb_q;
    assign bus.seq_step = step_q;
    assign bus.nmi_pend = nmi_pend;
endmodule

// File: tb/tb_cu_int_seq.sv
// Scoreboard bench for cu_int_seq: directed scenarios plus random traffic.
// Expected requests/sequences are queued at issue time and popped by a monitor.
module tb_cu_int_seq;
    localparam int N  = 4;
    localparam int NS = 2;

    typedef struct {
        logic [1:0]  kind;
        int          chan;
        logic [15:0] vec;
        logic        setb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t req_q[$];
    exp_t seq_q[$];
    bit   pend_m = 1'b0;

    always #5 clk = ~clk;

    cu_int_seq_if #(.N_IRQ(N)) bus ();

    cu_int_seq #(.N_IRQ(N), .NMI_SYNC(NS)) dut (
        .CU_phi2 (clk),
        .CU_rst  (rst),
        .bus     (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference arbitration: NMI > lowest enabled IRQ (unless masked) > BRK.
    function automatic exp_t arb(input bit nmi, input logic [N-1:0] birq,
                                 input logic [N-1:0] en, input bit flag,
                                 input bit brk, output bit hit);
        exp_t e;
        bit   found;
        e.kind = 2'b01;
        e.chan = 0;
        e.vec  = 16'h0000;
        e.setb = 1'b0;
        hit    = 1'b0;
        found  = 1'b0;
        if (nmi) begin
            hit = 1'b1;
            e.kind = 2'b10;
            e.vec  = 16'hFFFA;
        end else begin
            if (!flag) begin
                for (int c = 0; c < N; c++) begin
                    if (!found && !birq[c] && en[c]) begin
                        found  = 1'b1;
                        e.kind = 2'b11;
                        e.chan = c;
                        e.vec  = (c == 0) ? 16'hFFFE : 16'(32'hFFF0 + 2 * (c - 1));
                    end
                end
            end
            if (found) begin
                hit = 1'b1;
            end else if (brk) begin
                hit = 1'b1;
                e.kind = 2'b00;
                e.vec  = 16'hFFFE;
                e.setb = 1'b1;
            end
        end
        return e;
    endfunction

    // Monitor: checks request content on ack and the whole 7-step sequence.
    int   step_exp = 0;
    bit   was_last = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            step_exp = 0;
            was_last = 1'b0;
        end else begin
            if (was_last) chk("seq_end_busy", 32'(bus.seq_busy), 32'd0);
            was_last = 1'b0;
            if (bus.int_req && bus.int_ack) begin
                if (req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL req_unexpected: got kind %0h want none", bus.int_kind);
                end else begin
                    mon_e = req_q.pop_front();
                    chk("req_kind", 32'(bus.int_kind), 32'(mon_e.kind));
                    chk("req_vec", 32'(bus.vec_addr), 32'(mon_e.vec));
                    chk("req_setb", 32'(bus.set_b), 32'(mon_e.setb));
                    if (mon_e.kind == 2'b11)
                        chk("req_chan", 32'(bus.int_chan), 32'(mon_e.chan));
                end
            end
            if (bus.seq_busy) begin
                chk("seq_step", 32'(bus.seq_step), 32'(step_exp));
                if (step_exp == 6) begin
                    if (seq_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL seq_unexpected: got kind %0h want none", bus.int_kind);
                    end else begin
                        mon_e = seq_q.pop_front();
                        chk("seq_kind", 32'(bus.int_kind), 32'(mon_e.kind));
                        chk("seq_vec", 32'(bus.vec_addr), 32'(mon_e.vec));
                        chk("seq_setb", 32'(bus.set_b), 32'(mon_e.setb));
                    end
                    was_last = 1'b1;
                    step_exp = 0;
                end else begin
                    step_exp++;
                end
            end else begin
                step_exp = 0;
            end
        end
    end

    task automatic cyc(input int n = 1);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic bnd(input bit brk);
        bus.insn_bnd = 1'b1;
        bus.brk_op   = brk;
        cyc();
        bus.insn_bnd = 1'b0;
        bus.brk_op   = 1'b0;
    endtask

    // mode 0: plain; 1: NMI edge driven with ack (pending by step 2);
    // 2: NMI edge driven at step 4 (too late to hijack, stays pending).
    task automatic service(input int mode, input int dly);
        int n;
        n = 0;
        while (!bus.int_req && n < 20) begin
            cyc();
            n++;
        end
        if (!bus.int_req) begin
            checks++;
            failures++;
            $display("FAIL req_timeout: got int_req 0 want 1");
            return;
        end
        bus.CU_bIRQ = N'($urandom);
        cyc(dly);
        bus.int_ack = 1'b1;
        if (mode == 1) bus.CU_bNMI = 1'b0;
        cyc();
        bus.int_ack = 1'b0;
        if (mode == 2) begin
            cyc(4);
            bus.CU_bNMI = 1'b0;
        end
        n = 0;
        while (bus.seq_busy && n < 20) begin
            cyc();
            n++;
        end
        if (bus.seq_busy) begin
            checks++;
            failures++;
            $display("FAIL seq_timeout: got seq_busy 1 want 0");
        end
        bus.CU_bNMI = 1'b1;
        cyc(4);
    endtask

    task automatic issue(input bit brk, input int mode, input int dly,
                         input bit nmi_edge);
        exp_t e;
        bit   hit;
        int   m;
        e = arb(pend_m | nmi_edge, bus.CU_bIRQ, bus.irq_en, bus.flag_i, brk, hit);
        if (!nmi_edge) chk("nmi_pend", 32'(bus.nmi_pend), 32'(pend_m));
        chk("idle_no_req", 32'(bus.int_req), 32'd0);
        bnd(brk);
        if (!hit) begin
            chk("no_req", 32'(bus.int_req), 32'd0);
            return;
        end
        chk("req_latency", 32'(bus.int_req), 32'd1);
        m = (e.kind == 2'b10) ? 0 : mode;
        req_q.push_back(e);
        if (m == 1) begin
            e.kind = 2'b10;
            e.vec  = 16'hFFFA;
        end
        seq_q.push_back(e);
        if (e.kind == 2'b10) pend_m = 1'b0;
        if (m == 2) pend_m = 1'b1;
        service(m, dly);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t r;
        bus.CU_bNMI  = 1'b1;
        bus.CU_bIRQ  = '1;
        bus.irq_en   = '1;
        bus.flag_i   = 1'b0;
        bus.insn_bnd = 1'b0;
        bus.brk_op   = 1'b0;
        bus.int_ack  = 1'b0;
        r.kind = 2'b01;
        r.chan = 0;
        r.vec  = 16'hFFFC;
        r.setb = 1'b0;

        cyc(3);
        chk("rst_req", 32'(bus.int_req), 32'd1);
        chk("rst_kind", 32'(bus.int_kind), 32'd1);
        chk("rst_vec", 32'(bus.vec_addr), 32'hFFFC);
        chk("rst_setb", 32'(bus.set_b), 32'd0);
        chk("rst_busy", 32'(bus.seq_busy), 32'd0);
        chk("rst_step", 32'(bus.seq_step), 32'd0);
        chk("rst_pend", 32'(bus.nmi_pend), 32'd0);
        chk("rst_chan", 32'(bus.int_chan), 32'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_req", 32'(bus.int_req), 32'd1);
        chk("post_rst_kind", 32'(bus.int_kind), 32'd1);
        req_q.push_back(r);
        seq_q.push_back(r);
        service(0, 1);

        bus.CU_bIRQ = 4'b1001;
        cyc();
        issue(1'b0, 0, 2, 1'b0);

        bus.CU_bIRQ = 4'b1110;
        bus.CU_bNMI = 1'b0;
        cyc(NS);
        issue(1'b0, 0, 0, 1'b1);
        bus.CU_bIRQ = 4'b1110;
        cyc();
        issue(1'b0, 0, 0, 1'b0);

        bus.CU_bIRQ = '1;
        cyc();
        issue(1'b1, 1, 0, 1'b0);

        bus.CU_bIRQ = '0;
        bus.flag_i  = 1'b1;
        for (int i = 0; i < 10; i++) issue(1'b0, 0, 0, 1'b0);
        bus.flag_i = 1'b0;
        issue(1'b0, 0, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0 && !pend_m) begin
                bus.CU_bNMI = 1'b0;
                cyc(4);
                bus.CU_bNMI = 1'b1;
                cyc(3);
                pend_m = 1'b1;
            end
            bus.CU_bIRQ = N'($urandom);
            bus.irq_en  = N'($urandom);
            bus.flag_i  = ($urandom_range(0, 3) == 0);
            cyc();
            issue($urandom_range(0, 2) == 0, $urandom_range(0, 2),
                  $urandom_range(0, 3), 1'b0);
        end

        bus.CU_bIRQ = 4'b1011;
        bus.irq_en  = '1;
        bus.flag_i  = 1'b0;
        cyc();
        chk("pre_abort_pend", 32'(bus.nmi_pend), 32'(pend_m));
        r.kind = 2'b11;
        r.chan = 2;
        r.vec  = 16'hFFF2;
        bnd(1'b0);
        chk("abort_req", 32'(bus.int_req), 32'd1);
        req_q.push_back(r);
        bus.int_ack = 1'b1;
        bus.CU_bNMI = 1'b0;
        cyc();
        bus.int_ack = 1'b0;
        cyc(3);
        chk("abort_step", 32'(bus.seq_step), 32'd3);
        chk("abort_pend_set", 32'(bus.nmi_pend), 32'd1);
        rst = 1'b1;
        bus.CU_bNMI = 1'b1;
        #1;
        chk("abort_req_rst", 32'(bus.int_req), 32'd1);
        chk("abort_kind", 32'(bus.int_kind), 32'd1);
        chk("abort_vec", 32'(bus.vec_addr), 32'hFFFC);
        chk("abort_busy", 32'(bus.seq_busy), 32'd0);
        chk("abort_pend", 32'(bus.nmi_pend), 32'd0);
        cyc(2);
        rst = 1'b0;
        pend_m = 1'b0;
        r.kind = 2'b01;
        r.chan = 0;
        r.vec  = 16'hFFFC;
        r.setb = 1'b0;
        req_q.push_back(r);
        seq_q.push_back(r);
        bus.CU_bIRQ = '1;
        service(0, 0);

        cyc(5);
        chk("req_q_drain", 32'(req_q.size()), 32'd0);
        chk("seq_q_drain", 32'(seq_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
